// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave fully synchronous to CLK. SCLK, CS_N and MOSI are
// oversampled; supports all CPOL/CPHA modes, either bit order, a one-deep TX
// holding register, an RX word strobe and an underrun strobe.
//
// state  | meaning
// IDLE   | deselected (or frame ignored after reset); SCLK edges ignored, MISO/MISO_OE low
// ACTIVE | selected; shift edges drive MISO, sample edges assemble the RX word
module spi_slave_sync #(
   parameter int WIDTH       = 9,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SCLK,
   input  logic             CS_N,
   input  logic             MOSI,
   output logic             MISO,
   output logic             MISO_OE,
   input  logic [WIDTH-1:0] TX_DATA,
   input  logic             TX_VALID,
   output logic             TX_READY,
   output logic [WIDTH-1:0] RX_DATA,
   output logic             RX_VALID,
   output logic             UNDERRUN
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_prev, cs_prev;
   logic [SYNC_STAGES:0]   flush_q;
   logic                   armed;

   logic sclk_s, cs_s, mosi_s;
   logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;

   logic sel, abort, load, shift_en, sample_en, tx_wr;

   logic [WIDTH-1:0] hold_data, tx_shift, rx_shift, tx_shifted, rx_shifted;
   logic             hold_full, rx_pend;
   logic [CNT_W-1:0] bit_cnt;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign lead_edge   = (sclk_prev == CPOL) && (sclk_s != CPOL);
   assign trail_edge  = (sclk_prev != CPOL) && (sclk_s == CPOL);
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;

   // A falling CS_N only counts once CS_N has been seen high on real pin samples,
   // so a frame already in progress at reset release is ignored.
   assign cs_fall = armed && cs_prev && !cs_s;

   assign tx_shifted = MSB_FIRST ? {tx_shift[WIDTH-2:0], 1'b0} : {1'b0, tx_shift[WIDTH-1:1]};
   assign rx_shifted = MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_s} : {mosi_s, rx_shift[WIDTH-1:1]};

   assign tx_wr    = TX_VALID && !hold_full;
   assign TX_READY = !hold_full;
   assign MISO_OE  = sel;
   assign MISO     = sel && (MSB_FIRST ? tx_shift[WIDTH-1] : tx_shift[0]);

   // input synchronisers, edge-detect flops and post-reset arming
   always_ff @(posedge CLK) begin
      if (RST) begin
         sclk_sync <= {SYNC_STAGES{CPOL}};
         cs_sync   <= {SYNC_STAGES{1'b1}};
         mosi_sync <= '0;
         sclk_prev <= CPOL;
         cs_prev   <= 1'b1;
         flush_q   <= '0;
         armed     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
         flush_q   <= {flush_q[SYNC_STAGES-1:0], 1'b1};
         if (flush_q[SYNC_STAGES] && cs_s) armed <= 1'b1;
      end
   end

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state and per-cycle control strobes
   always_comb begin
      state_d   = state_q;
      sel       = 1'b0;
      abort     = 1'b0;
      load      = 1'b0;
      shift_en  = 1'b0;
      sample_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = ACTIVE;
               load    = ~CPHA;
            end
         end
         ACTIVE: begin
            if (cs_s) begin
               state_d = IDLE;
               abort   = 1'b1;
            end else begin
               sel       = 1'b1;
               shift_en  = shift_edge;
               sample_en = sample_edge;
               load      = shift_edge && (bit_cnt == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // datapath: holding register, TX/RX shift registers, bit counter, strobes
   always_ff @(posedge CLK) begin
      if (RST) begin
         hold_data <= '0;
         hold_full <= 1'b0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         rx_pend   <= 1'b0;
         RX_DATA   <= '0;
         RX_VALID  <= 1'b0;
         UNDERRUN  <= 1'b0;
      end else begin
         if (abort) begin
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
         end else begin
            if (load)          tx_shift <= hold_full ? hold_data : '0;
            else if (shift_en) tx_shift <= tx_shifted;
            if (sample_en) begin
               rx_shift <= rx_shifted;
               bit_cnt  <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
            end
         end
         rx_pend  <= sample_en && (bit_cnt == CNT_LAST);
         RX_VALID <= rx_pend;
         if (rx_pend) RX_DATA <= rx_shift;
         UNDERRUN <= load && !hold_full;
         // a load sees the pre-write holding state; a same-cycle write lands afterwards
         if (load && hold_full) begin
            hold_full <= 1'b0;
         end else if (tx_wr) begin
            hold_data <= TX_DATA;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: drives six slave instances (four modes, both bit orders) as an
// SPI master; a frame-level model predicts MISO words, RX words and underruns.
module tb_spi_slave_sync;

   localparam int W    = 9;
   localparam int NI   = 6;
   localparam int HALF = 8;
   // instance: 0 mode0 msb, 1 mode1 msb, 2 mode2 msb, 3 mode3 msb, 4 mode0 lsb, 5 mode3 lsb
   localparam bit [NI-1:0] P_CPOL = 6'b101100;
   localparam bit [NI-1:0] P_CPHA = 6'b101010;
   localparam bit [NI-1:0] P_MSB  = 6'b001111;

   logic clk = 1'b0;
   logic rst;
   logic [NI-1:0] sclk, cs_n, mosi, tx_valid;
   logic [NI-1:0] miso, miso_oe, tx_ready, rx_valid, underrun;
   logic [W-1:0]  tx_data [NI];
   logic [W-1:0]  rx_data [NI];

   int cur;
   int n_vec = 0;
   int n_err = 0;
   int exp_underruns = 0;
   int act_underruns = 0;

   logic [W-1:0] feed_q[$];
   logic [W-1:0] mdl_tx[$];
   logic [W-1:0] exp_rx[$];
   logic [W-1:0] exp_miso[$];
   logic [W-1:0] frame_mosi[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      spi_slave_sync #(
         .WIDTH(W), .CPOL(P_CPOL[g]), .CPHA(P_CPHA[g]),
         .MSB_FIRST(P_MSB[g]), .SYNC_STAGES(2)
      ) u_dut (
         .CLK(clk), .RST(rst), .SCLK(sclk[g]), .CS_N(cs_n[g]), .MOSI(mosi[g]),
         .MISO(miso[g]), .MISO_OE(miso_oe[g]),
         .TX_DATA(tx_data[g]), .TX_VALID(tx_valid[g]), .TX_READY(tx_ready[g]),
         .RX_DATA(rx_data[g]), .RX_VALID(rx_valid[g]), .UNDERRUN(underrun[g])
      );
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (inst %0d, t=%0t)", name, act, exp, cur, $time);
      end
   endfunction

   // frame-level reference: loads take queued words in order (zero + underrun when none),
   // CPHA=0 loads at select and after every complete word, CPHA=1 once per word started
   task automatic model_frame(input int nbits, input bit cpha);
      int comp, loads;
      logic [W-1:0] w;
      comp  = nbits / W;
      loads = cpha ? (nbits + W - 1) / W : 1 + comp;
      for (int j = 0; j < loads; j++) begin
         if (mdl_tx.size() > 0) w = mdl_tx.pop_front();
         else begin
            w = '0;
            exp_underruns++;
         end
         if (j < comp) exp_miso.push_back(w);
      end
      for (int j = 0; j < comp; j++) exp_rx.push_back(frame_mosi[j]);
   endtask

   task automatic feed(input logic [W-1:0] w);
      feed_q.push_back(w);
      mdl_tx.push_back(w);
   endtask

   task automatic spi_xfer(input int nbits, input bit chk_miso, input bit raise_cs, input bit exp_oe);
      logic [W-1:0] mw, rw;
      int k, bp;
      bit pol, pha, msb;
      pol = P_CPOL[cur];
      pha = P_CPHA[cur];
      msb = P_MSB[cur];
      mw  = '0;
      rw  = '0;
      cs_n[cur] = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         k  = b % W;
         bp = msb ? W - 1 - k : k;
         if (k == 0) begin
            mw = frame_mosi[b / W];
            rw = '0;
         end
         if (!pha) begin
            mosi[cur] = mw[bp];
            repeat (HALF) @(negedge clk);
            rw[bp] = miso[cur];
            chk("miso_oe", 32'(miso_oe[cur]), 32'(exp_oe));
            sclk[cur] = ~pol;
            repeat (HALF) @(negedge clk);
            sclk[cur] = pol;
         end else begin
            repeat (HALF) @(negedge clk);
            sclk[cur] = ~pol;
            mosi[cur] = mw[bp];
            repeat (HALF) @(negedge clk);
            rw[bp] = miso[cur];
            chk("miso_oe", 32'(miso_oe[cur]), 32'(exp_oe));
            sclk[cur] = pol;
         end
         if (chk_miso && k == W - 1) begin
            if (exp_miso.size() > 0) chk("miso_word", 32'(rw), 32'(exp_miso.pop_front()));
            else chk("miso_word_unexpected", 32'(rw), 32'(rw) ^ 32'h1);
         end
      end
      repeat (HALF) @(negedge clk);
      if (raise_cs) cs_n[cur] = 1'b1;
   endtask

   task automatic frame_end_checks();
      repeat (2 * HALF) @(negedge clk);
      chk("rx_pending", 32'(exp_rx.size()), 32'd0);
      chk("underrun_count", 32'(act_underruns), 32'(exp_underruns));
      chk("miso_idle", 32'(miso[cur]), 32'd0);
      chk("miso_oe_idle", 32'(miso_oe[cur]), 32'd0);
      exp_rx.delete();
      exp_miso.delete();
      act_underruns = exp_underruns;
   endtask

   task automatic run_frame(input int nbits);
      repeat (4) @(negedge clk);
      model_frame(nbits, P_CPHA[cur]);
      spi_xfer(nbits, 1'b1, 1'b1, 1'b1);
      frame_end_checks();
   endtask

   task automatic check_reset(input int i);
      chk("rst_miso", 32'(miso[i]), 32'd0);
      chk("rst_miso_oe", 32'(miso_oe[i]), 32'd0);
      chk("rst_rx_data", 32'(rx_data[i]), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid[i]), 32'd0);
      chk("rst_underrun", 32'(underrun[i]), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready[i]), 32'd1);
   endtask

   // TX feeder: writes queued words into the holding register as it empties
   initial begin
      tx_valid = '0;
      for (int i = 0; i < NI; i++) tx_data[i] = '0;
      forever begin
         @(negedge clk);
         if (!rst && feed_q.size() > 0 && tx_ready[cur]) begin
            tx_data[cur]  = feed_q.pop_front();
            tx_valid[cur] = 1'b1;
            @(negedge clk);
            tx_valid[cur] = 1'b0;
         end
      end
   end

   // monitor: compares each RX_VALID word against the scoreboard, counts underruns
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (rx_valid[cur]) begin
               if (exp_rx.size() > 0) chk("rx_data", 32'(rx_data[cur]), 32'(exp_rx.pop_front()));
               else chk("rx_valid_unexpected", 32'(rx_valid[cur]), 32'd0);
            end
            if (underrun[cur]) act_underruns++;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nbits, nfeed, loads;
      rst = 1'b1;
      cur = 0;
      for (int i = 0; i < NI; i++) begin
         sclk[i] = P_CPOL[i];
         cs_n[i] = 1'b1;
         mosi[i] = 1'b0;
      end
      repeat (5) @(negedge clk);
      for (int i = 0; i < NI; i++) check_reset(i);
      rst = 1'b0;
      repeat (2 * HALF) @(negedge clk);

      // basic exchange in every mode / bit order
      for (int i = 0; i < NI; i++) begin
         cur = i;
         feed(9'h1A5);
         frame_mosi.delete();
         frame_mosi.push_back(9'h0F3);
         run_frame(W);
      end

      // two words in one frame, second written once TX_READY rises
      cur = 1;
      feed(9'h155);
      feed(9'h0AA);
      frame_mosi.delete();
      frame_mosi.push_back(W'($urandom));
      frame_mosi.push_back(W'($urandom));
      run_frame(2 * W);

      // nothing written: underrun, zeros on MISO, RX still captured
      cur = 1;
      frame_mosi.delete();
      frame_mosi.push_back(W'($urandom));
      run_frame(W);

      // partial word aborted, then a full 1FF word
      cur = 0;
      feed(W'($urandom));
      frame_mosi.delete();
      frame_mosi.push_back(W'($urandom));
      run_frame(5);
      feed(W'($urandom));
      frame_mosi.delete();
      frame_mosi.push_back(9'h1FF);
      run_frame(W);

      // reset mid-frame with CS_N held low; the remainder of that frame is ignored
      cur = 0;
      feed(W'($urandom));
      frame_mosi.delete();
      frame_mosi.push_back(W'($urandom));
      repeat (4) @(negedge clk);
      model_frame(4, P_CPHA[cur]);
      spi_xfer(4, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset(cur);
      spi_xfer(W, 1'b0, 1'b1, 1'b0);
      frame_end_checks();
      feed(W'($urandom));
      frame_mosi.delete();
      frame_mosi.push_back(W'($urandom));
      run_frame(W);

      // randomized frames: random length (including partial words) and TX supply
      for (int i = 0; i < NI; i++) begin
         cur = i;
         for (int f = 0; f < 5; f++) begin
            nbits = $urandom_range(1, 3 * W);
            loads = P_CPHA[cur] ? (nbits + W - 1) / W : 1 + nbits / W;
            nfeed = $urandom_range(0, loads);
            for (int j = 0; j < nfeed; j++) feed(W'($urandom));
            frame_mosi.delete();
            for (int j = 0; j < (nbits + W - 1) / W; j++) frame_mosi.push_back(W'($urandom));
            run_frame(nbits);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
